// File: rtl/axi_ohs_pkg.sv
// rtl/axi_ohs_pkg.sv - shared constants, FSM state types and strobe helper for the AXI4-Lite register bank
package axi_ohs_pkg;

    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_STRB_WIDTH = 4;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE,
        WR_ADDR,
        WR_DATA,
        WR_RESP
    } wr_state_e;

    typedef enum logic {
        RD_IDLE,
        RD_VALID
    } rd_state_e;

    // Expands a byte strobe into a per-bit write mask.
    function automatic logic [AXI_DATA_WIDTH-1:0] strb_to_mask(input logic [AXI_STRB_WIDTH-1:0] strb);
        logic [AXI_DATA_WIDTH-1:0] mask;
        mask = '0;
        for (int b = 0; b < AXI_STRB_WIDTH; b++) begin
            mask[b*8 +: 8] = {8{strb[b]}};
        end
        return mask;
    endfunction

endpackage

// File: rtl/axi_ohs_wstrb_merge.sv
// rtl/axi_ohs_wstrb_merge.sv - byte-strobe merge of new write data over the prior register word
module axi_ohs_wstrb_merge
    import axi_ohs_pkg::*;
(
    input  logic [AXI_DATA_WIDTH-1:0] prior_i,
    input  logic [AXI_DATA_WIDTH-1:0] data_i,
    input  logic [AXI_STRB_WIDTH-1:0] strb_i,
    output logic [AXI_DATA_WIDTH-1:0] merged_o
);

    logic [AXI_DATA_WIDTH-1:0] mask;

    assign mask     = strb_to_mask(strb_i);
    assign merged_o = (data_i & mask) | (prior_i & ~mask);

endmodule

// File: rtl/axi_ohs_regbank.sv
// rtl/axi_ohs_regbank.sv - AXI4-Lite slave bank of N_REGS R/W or hardware-driven RO registers
// Optional AXI_OHS_REGBANK_SLVERR_EN: SLVERR on RO/out-of-range writes and out-of-range reads.
module axi_ohs_regbank
    import axi_ohs_pkg::*;
#(
    parameter int                N_REGS           = 8,
    parameter int                C_AXI_ADDR_WIDTH = 5,
    parameter logic [N_REGS-1:0] RO_MASK          = '0
) (
    input  logic                          s_axi_aclk,
    input  logic                          s_axi_areset,

    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,

    input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [AXI_STRB_WIDTH-1:0]     s_axi_wstrb,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,

    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,

    input  logic [C_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,

    output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready,

    output logic [N_REGS*32-1:0]          reg_out,
    input  logic [N_REGS*32-1:0]          hw_in,
    output logic [N_REGS-1:0]             wr_pulse
);

    localparam int IDX_W = C_AXI_ADDR_WIDTH - 2;

    wr_state_e                 wr_state_q;
    logic [IDX_W-1:0]          aw_idx_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [AXI_STRB_WIDTH-1:0] wstrb_q;
    logic                      awready_q;
    logic                      wready_q;
    logic                      bvalid_q;
    logic [1:0]                bresp_q;
    logic [N_REGS-1:0]         wr_pulse_q;

    rd_state_e                 rd_state_q;
    logic                      arready_q;
    logic                      rvalid_q;
    logic [1:0]                rresp_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;

    logic [IDX_W-1:0]          aw_idx_in;
    logic [IDX_W-1:0]          rd_idx;
    logic                      commit_en;
    logic [IDX_W-1:0]          commit_idx;
    logic [AXI_DATA_WIDTH-1:0] commit_data;
    logic [AXI_STRB_WIDTH-1:0] commit_strb;
    logic [N_REGS-1:0]         wr_hit;
    logic [1:0]                wr_resp;
    logic [1:0]                rd_resp;
    logic [AXI_DATA_WIDTH-1:0] rd_val;
    logic [AXI_DATA_WIDTH-1:0] cur [N_REGS];
    logic                      unused_addr_lsbs;

    assign aw_idx_in        = s_axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
    assign rd_idx           = s_axi_araddr[C_AXI_ADDR_WIDTH-1:2];
    assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Readies are registered but forced low while reset is held.
    assign s_axi_awready = awready_q & ~s_axi_areset;
    assign s_axi_wready  = wready_q  & ~s_axi_areset;
    assign s_axi_arready = arready_q & ~s_axi_areset;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;
    assign wr_pulse      = wr_pulse_q;

    // The write completes on whichever edge sees the second of AW/W.
    always_comb begin
        commit_en   = 1'b0;
        commit_idx  = aw_idx_in;
        commit_data = s_axi_wdata;
        commit_strb = s_axi_wstrb;
        unique case (wr_state_q)
            WR_IDLE: commit_en = s_axi_awvalid & s_axi_wvalid;
            WR_ADDR: begin
                commit_en  = s_axi_wvalid;
                commit_idx = aw_idx_q;
            end
            WR_DATA: begin
                commit_en   = s_axi_awvalid;
                commit_data = wdata_q;
                commit_strb = wstrb_q;
            end
            default: commit_en = 1'b0;
        endcase
    end

    always_comb begin
        wr_hit = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (commit_en && int'(commit_idx) == i && !RO_MASK[i]) begin
                wr_hit[i] = 1'b1;
            end
        end
    end

`ifdef AXI_OHS_REGBANK_SLVERR_EN
    logic rd_in_range;
    assign rd_in_range = int'(rd_idx) < N_REGS;
    assign wr_resp     = (|wr_hit) ? RESP_OKAY : RESP_SLVERR;
    assign rd_resp     = rd_in_range ? RESP_OKAY : RESP_SLVERR;
`else
    assign wr_resp = RESP_OKAY;
    assign rd_resp = RESP_OKAY;
`endif

    for (genvar i = 0; i < N_REGS; i++) begin : g_reg
        if (RO_MASK[i]) begin : g_ro
            assign cur[i] = '0;
        end else begin : g_rw
            logic [AXI_DATA_WIDTH-1:0] data_q;
            logic [AXI_DATA_WIDTH-1:0] data_d;

            axi_ohs_wstrb_merge u_merge (
                .prior_i  (data_q),
                .data_i   (commit_data),
                .strb_i   (commit_strb),
                .merged_o (data_d)
            );

            always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
                if (s_axi_areset) begin
                    data_q <= '0;
                end else if (wr_hit[i]) begin
                    data_q <= data_d;
                end
            end

            assign cur[i] = data_q;
        end
        assign reg_out[i*32 +: 32] = cur[i];
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            wr_state_q <= WR_IDLE;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            wr_pulse_q <= wr_hit;
            if (commit_en) begin
                wr_state_q <= WR_RESP;
                awready_q  <= 1'b0;
                wready_q   <= 1'b0;
                bvalid_q   <= 1'b1;
                bresp_q    <= wr_resp;
            end else begin
                unique case (wr_state_q)
                    WR_IDLE: begin
                        if (s_axi_awvalid) begin
                            aw_idx_q   <= aw_idx_in;
                            awready_q  <= 1'b0;
                            wr_state_q <= WR_ADDR;
                        end else if (s_axi_wvalid) begin
                            wdata_q    <= s_axi_wdata;
                            wstrb_q    <= s_axi_wstrb;
                            wready_q   <= 1'b0;
                            wr_state_q <= WR_DATA;
                        end
                    end
                    WR_RESP: begin
                        if (s_axi_bready) begin
                            bvalid_q   <= 1'b0;
                            awready_q  <= 1'b1;
                            wready_q   <= 1'b1;
                            wr_state_q <= WR_IDLE;
                        end
                    end
                    default: wr_state_q <= wr_state_q;
                endcase
            end
        end
    end

    // Reads see the pre-commit register value, so a same-edge write is not visible yet.
    always_comb begin
        rd_val = '0;
        for (int i = 0; i < N_REGS; i++) begin
            if (int'(rd_idx) == i) begin
                rd_val = RO_MASK[i] ? hw_in[i*32 +: 32] : cur[i];
            end
        end
    end

    always_ff @(posedge s_axi_aclk or posedge s_axi_areset) begin
        if (s_axi_areset) begin
            rd_state_q <= RD_IDLE;
            arready_q  <= 1'b1;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            unique case (rd_state_q)
                RD_IDLE: begin
                    if (s_axi_arvalid) begin
                        rdata_q    <= rd_val;
                        rresp_q    <= rd_resp;
                        rvalid_q   <= 1'b1;
                        arready_q  <= 1'b0;
                        rd_state_q <= RD_VALID;
                    end
                end
                RD_VALID: begin
                    if (s_axi_rready) begin
                        rvalid_q   <= 1'b0;
                        arready_q  <= 1'b1;
                        rd_state_q <= RD_IDLE;
                    end
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_ohs_regbank.sv
// tb/tb_axi_ohs_regbank.sv - scoreboard bench for axi_ohs_regbank (5 registers, register 0 read-only)
module tb_axi_ohs_regbank;

    localparam int N = 5;
`ifdef AXI_OHS_REGBANK_SLVERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    logic          clk;
    logic          rst;
    logic [4:0]    s_axi_awaddr;
    logic          s_axi_awvalid;
    logic          s_axi_awready;
    logic [31:0]   s_axi_wdata;
    logic [3:0]    s_axi_wstrb;
    logic          s_axi_wvalid;
    logic          s_axi_wready;
    logic [1:0]    s_axi_bresp;
    logic          s_axi_bvalid;
    logic          s_axi_bready;
    logic [4:0]    s_axi_araddr;
    logic          s_axi_arvalid;
    logic          s_axi_arready;
    logic [31:0]   s_axi_rdata;
    logic [1:0]    s_axi_rresp;
    logic          s_axi_rvalid;
    logic          s_axi_rready;
    logic [N*32-1:0] reg_out;
    logic [N*32-1:0] hw_in;
    logic [N-1:0]  wr_pulse;

    typedef struct {
        logic [1:0]      resp;
        logic [N-1:0]    pulse;
        logic [N*32-1:0] regs;
    } b_exp_t;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } r_exp_t;

    b_exp_t      exp_b[$];
    r_exp_t      exp_r[$];
    logic [31:0] model [N];
    int          checks = 0;
    int          errors = 0;
    logic        bvalid_prev = 1'b0;

    axi_ohs_regbank #(
        .N_REGS           (N),
        .C_AXI_ADDR_WIDTH (5),
        .RO_MASK          (5'b00001)
    ) dut (
        .s_axi_aclk    (clk),
        .s_axi_areset  (rst),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .reg_out       (reg_out),
        .hw_in         (hw_in),
        .wr_pulse      (wr_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N*32-1:0] act, input logic [N*32-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [N*32-1:0] pack_model();
        logic [N*32-1:0] p;
        for (int i = 0; i < N; i++) p[i*32 +: 32] = model[i];
        return p;
    endfunction

    // Scoreboard monitor: compares whatever the DUT presents against the queue heads.
    always @(negedge clk) begin
        if (rst) begin
            bvalid_prev = 1'b0;
        end else begin
            if (s_axi_bvalid) begin
                if (exp_b.size() == 0) begin
                    fail_now("unexpected_bvalid");
                end else begin
                    chk("bresp", s_axi_bresp, exp_b[0].resp);
                    if (!bvalid_prev) begin
                        chk("wr_pulse", wr_pulse, exp_b[0].pulse);
                        chk("reg_out", reg_out, exp_b[0].regs);
                    end
                    if (s_axi_bready) void'(exp_b.pop_front());
                end
            end
            if (!(s_axi_bvalid && !bvalid_prev)) chk("wr_pulse_idle", wr_pulse, '0);
            if (s_axi_rvalid) begin
                if (exp_r.size() == 0) begin
                    fail_now("unexpected_rvalid");
                end else begin
                    chk("rdata", s_axi_rdata, exp_r[0].data);
                    chk("rresp", s_axi_rresp, exp_r[0].resp);
                    if (s_axi_rready) void'(exp_r.pop_front());
                end
            end
            bvalid_prev = s_axi_bvalid;
        end
    end

    task automatic write_txn(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_at, input int w_at, input int bhold,
                             input logic [N-1:0] exp_pulse, input logic [1:0] exp_resp);
        b_exp_t e;
        int     c;
        int     idx;
        bit     aw_done, w_done, aw_hs, w_hs, hs;
        idx = int'(addr[4:2]);
        if (idx >= 1 && idx < N) begin
            for (int b = 0; b < 4; b++) if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
        end
        e.resp  = exp_resp;
        e.pulse = exp_pulse;
        e.regs  = pack_model();
        exp_b.push_back(e);
        s_axi_bready = (bhold == 0);
        c = 0; aw_done = 0; w_done = 0;
        while (!(aw_done && w_done) && c < 50) begin
            s_axi_awvalid = !aw_done && (c >= aw_at);
            s_axi_awaddr  = addr;
            s_axi_wvalid  = !w_done && (c >= w_at);
            s_axi_wdata   = data;
            s_axi_wstrb   = strb;
            @(negedge clk);
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid && s_axi_wready;
            if (aw_done && !w_done) chk("awready_held_low", s_axi_awready, 1'b0);
            if (w_done && !aw_done) chk("wready_held_low", s_axi_wready, 1'b0);
            @(posedge clk); #1;
            aw_done = aw_done | aw_hs;
            w_done  = w_done | w_hs;
            c++;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        if (!(aw_done && w_done)) fail_now("write_handshake_timeout");
        chk("b_latency", s_axi_bvalid, 1'b1);
        repeat (bhold) begin
            s_axi_awvalid = 1'b1;
            s_axi_wvalid  = 1'b1;
            @(negedge clk);
            chk("aw_w_blocked", {s_axi_awready, s_axi_wready}, 2'b00);
            @(posedge clk); #1;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        c = 0; hs = 0;
        while (!hs && c < 50) begin
            @(negedge clk);
            hs = s_axi_bvalid;
            @(posedge clk); #1;
            c++;
        end
        if (!hs) fail_now("bresp_timeout");
    endtask

    task automatic read_txn(input logic [4:0] addr, input int rhold,
                            input logic [31:0] exp_data, input logic [1:0] exp_resp);
        r_exp_t e;
        int     c;
        bit     hs;
        e.data = exp_data;
        e.resp = exp_resp;
        exp_r.push_back(e);
        s_axi_rready  = (rhold == 0);
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        c = 0; hs = 0;
        while (!hs && c < 50) begin
            @(negedge clk);
            hs = s_axi_arready;
            @(posedge clk); #1;
            c++;
        end
        s_axi_arvalid = 1'b0;
        if (!hs) fail_now("read_handshake_timeout");
        chk("r_latency", s_axi_rvalid, 1'b1);
        repeat (rhold) begin
            s_axi_arvalid = 1'b1;
            @(negedge clk);
            chk("ar_blocked", s_axi_arready, 1'b0);
            @(posedge clk); #1;
        end
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        c = 0; hs = 0;
        while (!hs && c < 50) begin
            @(negedge clk);
            hs = s_axi_rvalid;
            @(posedge clk); #1;
            c++;
        end
        if (!hs) fail_now("rdata_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b1;
        s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
        hw_in = {32'h5A5A0004, 32'h5A5A0003, 32'h5A5A0002, 32'h5A5A0001, 32'hCAFE0001};
        for (int i = 0; i < N; i++) model[i] = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_readies_low", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        chk("rst_valids_low", {s_axi_bvalid, s_axi_rvalid}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        chk("post_rst_resp", {s_axi_bresp, s_axi_rresp}, 4'h0);
        chk("post_rst_rdata", s_axi_rdata, 32'h0);
        chk("post_rst_reg_out", reg_out, '0);
        @(posedge clk); #1;

        write_txn(5'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 5'b00010, 2'b00);
        read_txn(5'h04, 0, 32'hDEADBEEF, 2'b00);

        write_txn(5'h08, 32'h11223344, 4'hF, 0, 0, 0, 5'b00100, 2'b00);
        write_txn(5'h08, 32'h0000ABCD, 4'h3, 0, 3, 0, 5'b00100, 2'b00);
        read_txn(5'h08, 0, 32'h1122ABCD, 2'b00);

        write_txn(5'h00, 32'h12345678, 4'hF, 0, 0, 0, 5'b00000, ERR);
        read_txn(5'h00, 0, 32'hCAFE0001, 2'b00);

        write_txn(5'h0C, 32'hA5A5A5A5, 4'h5, 0, 0, 5, 5'b01000, 2'b00);
        read_txn(5'h0C, 5, 32'h00A500A5, 2'b00);
        write_txn(5'h0C, 32'h11111111, 4'h2, 2, 0, 0, 5'b01000, 2'b00);
        read_txn(5'h0E, 0, 32'h00A511A5, 2'b00);

        read_txn(5'h18, 0, 32'h0, ERR);
        write_txn(5'h14, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 5'b00000, ERR);

        write_txn(5'h04, 32'h00000000, 4'h0, 0, 0, 0, 5'b00010, 2'b00);
        read_txn(5'h04, 0, 32'hDEADBEEF, 2'b00);

        fork
            write_txn(5'h10, 32'h00000077, 4'hF, 0, 0, 0, 5'b10000, 2'b00);
            read_txn(5'h10, 0, 32'h00000000, 2'b00);
        join
        read_txn(5'h10, 0, 32'h00000077, 2'b00);

        s_axi_awaddr  = 5'h04;
        s_axi_awvalid = 1'b1;
        @(posedge clk); #1;
        s_axi_awvalid = 1'b0;
        @(negedge clk);
        chk("wr_addr_awready", {s_axi_awready, s_axi_wready}, 2'b01);
        rst = 1'b1;
        #1;
        chk("mid_rst_readies", {s_axi_awready, s_axi_wready}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) model[i] = '0;
        @(negedge clk);
        chk("rel_readies", {s_axi_awready, s_axi_wready}, 2'b11);
        chk("rel_bvalid", s_axi_bvalid, 1'b0);
        chk("rel_reg_out", reg_out, '0);
        @(posedge clk); #1;
        read_txn(5'h04, 0, 32'h0, 2'b00);
        write_txn(5'h08, 32'hBEEF0000, 4'hC, 0, 0, 0, 5'b00100, 2'b00);
        read_txn(5'h08, 0, 32'hBEEF0000, 2'b00);

        repeat (3) @(posedge clk);
        chk("b_queue_drained", exp_b.size(), 0);
        chk("r_queue_drained", exp_r.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
